// File: rtl/flow_solver_pkg.sv
// Shared types and defaults for the Lucas-Kanade flow solver.
// tensor_t / flow_t are fixed at the default widths and used for stimulus and result records.
package flow_solver_pkg;

    localparam int unsigned ACCUM_WIDTH_DEF = 32;
    localparam int unsigned FLOW_WIDTH_DEF  = 16;
    localparam int unsigned FRAC_BITS_DEF   = 8;
    localparam int          DET_THRESH_DEF  = 16;
    localparam int unsigned X_W             = 10;
    localparam int unsigned Y_W             = 9;

    typedef struct packed {
        logic signed [ACCUM_WIDTH_DEF-1:0] ixix;
        logic signed [ACCUM_WIDTH_DEF-1:0] iyiy;
        logic signed [ACCUM_WIDTH_DEF-1:0] ixiy;
        logic signed [ACCUM_WIDTH_DEF-1:0] ixit;
        logic signed [ACCUM_WIDTH_DEF-1:0] iyit;
    } tensor_t;

    typedef struct packed {
        logic signed [FLOW_WIDTH_DEF-1:0] u;
        logic signed [FLOW_WIDTH_DEF-1:0] v;
        logic                             singular;
        logic                             sat;
    } flow_t;

    // P + D + S + divider + output register
    function automatic int unsigned latency(input int unsigned flow_width);
        return flow_width + 4;
    endfunction

endpackage

// File: rtl/flow_solver_if.sv
// Tensor-in / flow-out stream bundle for flow_solver.
// singular_count exists only when FLOW_SOLVER_STATS_EN is defined.
interface flow_solver_if import flow_solver_pkg::*; #(
    parameter int unsigned ACCUM_WIDTH = ACCUM_WIDTH_DEF,
    parameter int unsigned FLOW_WIDTH  = FLOW_WIDTH_DEF
);
    logic signed [ACCUM_WIDTH-1:0] sum_IxIx;
    logic signed [ACCUM_WIDTH-1:0] sum_IyIy;
    logic signed [ACCUM_WIDTH-1:0] sum_IxIy;
    logic signed [ACCUM_WIDTH-1:0] sum_IxIt;
    logic signed [ACCUM_WIDTH-1:0] sum_IyIt;
    logic                          accum_valid;
    logic [X_W-1:0]                accum_x_coord;
    logic [Y_W-1:0]                accum_y_coord;

    logic signed [FLOW_WIDTH-1:0]  flow_u;
    logic signed [FLOW_WIDTH-1:0]  flow_v;
    logic                          flow_singular;
    logic                          flow_sat;
    logic [X_W-1:0]                flow_x_coord;
    logic [Y_W-1:0]                flow_y_coord;
    logic                          flow_valid;
`ifdef FLOW_SOLVER_STATS_EN
    logic [15:0]                   singular_count;
`endif

    modport master (
        output sum_IxIx, sum_IyIy, sum_IxIy, sum_IxIt, sum_IyIt,
        output accum_valid, accum_x_coord, accum_y_coord,
`ifdef FLOW_SOLVER_STATS_EN
        input  singular_count,
`endif
        input  flow_u, flow_v, flow_singular, flow_sat, flow_x_coord, flow_y_coord, flow_valid
    );

    modport slave (
        input  sum_IxIx, sum_IyIy, sum_IxIy, sum_IxIt, sum_IyIt,
        input  accum_valid, accum_x_coord, accum_y_coord,
`ifdef FLOW_SOLVER_STATS_EN
        output singular_count,
`endif
        output flow_u, flow_v, flow_singular, flow_sat, flow_x_coord, flow_y_coord, flow_valid
    );

endinterface

// File: rtl/flow_solver_divider.sv
// Pipelined restoring divider: one quotient bit per stage, MSB first, magnitudes only.
// Caller guarantees dividend < divisor << Q_W; sideband travels with the data.
module flow_solver_divider #(
    parameter int unsigned DIVIDEND_W = 73,
    parameter int unsigned DIVISOR_W  = 65,
    parameter int unsigned Q_W        = 16,
    parameter int unsigned SIDE_W     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [DIVIDEND_W-1:0] dividend_i,
    input  logic [DIVISOR_W-1:0]  divisor_i,
    input  logic [SIDE_W-1:0]     side_i,
    output logic                  valid_o,
    output logic [Q_W-1:0]        quotient_o,
    output logic [SIDE_W-1:0]     side_o
);
    localparam int unsigned CW = DIVISOR_W + Q_W;

    logic [Q_W-1:0]        vld_q, vld_d;
    logic [DIVIDEND_W-1:0] rem_q [Q_W];
    logic [DIVIDEND_W-1:0] rem_d [Q_W];
    logic [DIVISOR_W-1:0]  dvs_q [Q_W];
    logic [DIVISOR_W-1:0]  dvs_d [Q_W];
    logic [Q_W-1:0]        quo_q [Q_W];
    logic [Q_W-1:0]        quo_d [Q_W];
    logic [SIDE_W-1:0]     side_q [Q_W];
    logic [SIDE_W-1:0]     side_d [Q_W];

    // Returns {quotient bit, new remainder} for a trial subtract of divisor << sh.
    function automatic logic [DIVIDEND_W:0] div_step(input logic [DIVIDEND_W-1:0] rem,
                                                     input logic [DIVISOR_W-1:0]  dvs,
                                                     input int unsigned           sh);
        logic [CW-1:0] trial;
        trial = CW'(dvs) << sh;
        if (CW'(rem) >= trial) return {1'b1, rem - trial[DIVIDEND_W-1:0]};
        return {1'b0, rem};
    endfunction

    always_comb begin
        logic [DIVIDEND_W:0] st;
        st        = div_step(dividend_i, divisor_i, Q_W - 1);
        rem_d[0]  = st[DIVIDEND_W-1:0];
        quo_d[0]  = '0;
        quo_d[0][Q_W-1] = st[DIVIDEND_W];
        dvs_d[0]  = divisor_i;
        side_d[0] = side_i;
        vld_d[0]  = valid_i;
        for (int unsigned s = 1; s < Q_W; s++) begin
            st        = div_step(rem_q[s-1], dvs_q[s-1], Q_W - 1 - s);
            rem_d[s]  = st[DIVIDEND_W-1:0];
            quo_d[s]  = quo_q[s-1];
            quo_d[s][Q_W-1-s] = st[DIVIDEND_W];
            dvs_d[s]  = dvs_q[s-1];
            side_d[s] = side_q[s-1];
            vld_d[s]  = vld_q[s-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int unsigned s = 0; s < Q_W; s++) begin
                rem_q[s]  <= '0;
                dvs_q[s]  <= '0;
                quo_q[s]  <= '0;
                side_q[s] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int unsigned s = 0; s < Q_W; s++) begin
                rem_q[s]  <= rem_d[s];
                dvs_q[s]  <= dvs_d[s];
                quo_q[s]  <= quo_d[s];
                side_q[s] <= side_d[s];
            end
        end
    end

    assign valid_o    = vld_q[Q_W-1];
    assign quotient_o = quo_q[Q_W-1];
    assign side_o     = side_q[Q_W-1];

endmodule

// File: rtl/flow_solver.sv
// Per-pixel 2x2 Lucas-Kanade solve by Cramer's rule, one pixel per clock, latency FLOW_WIDTH+4.
// Define FLOW_SOLVER_STATS_EN to add the per-frame singular_count output.
module flow_solver import flow_solver_pkg::*; #(
    parameter int unsigned ACCUM_WIDTH = ACCUM_WIDTH_DEF,
    parameter int unsigned FLOW_WIDTH  = FLOW_WIDTH_DEF,
    parameter int unsigned FRAC_BITS   = FRAC_BITS_DEF,
    parameter int          DET_THRESH  = DET_THRESH_DEF
) (
    input logic          clk,
    input logic          rst,
    flow_solver_if.slave bus_io
);
    localparam int unsigned PW       = 2 * ACCUM_WIDTH;
    localparam int unsigned DW       = PW + 1;
    localparam int unsigned NW       = DW + FRAC_BITS;
    localparam int unsigned CW       = DW + FLOW_WIDTH - 1;
    localparam int unsigned SIDE_U_W = 3 + X_W + Y_W;
    localparam logic signed [FLOW_WIDTH-1:0] SAT_POS = {1'b0, {(FLOW_WIDTH-1){1'b1}}};
    localparam logic signed [FLOW_WIDTH-1:0] SAT_NEG = -SAT_POS;

    logic                 p_valid_q, d_valid_q, s_valid_q;
    logic [X_W-1:0]       p_x_q, d_x_q, s_x_q;
    logic [Y_W-1:0]       p_y_q, d_y_q, s_y_q;
    logic signed [PW-1:0] p_ab_q, p_cc_q, p_ce_q, p_bd_q, p_cd_q, p_ae_q;
    logic signed [PW-1:0] p_ab_d, p_cc_d, p_ce_d, p_bd_d, p_cd_d, p_ae_d;
    logic signed [DW-1:0] det_q, nu_q, nv_q, det_d, nu_d, nv_d;
    logic [NW-1:0]        s_num_u_q, s_num_v_q, s_num_u_d, s_num_v_d;
    logic [DW-1:0]        s_det_q;
    logic                 s_sing_q, s_neg_u_q, s_neg_v_q, s_ovf_u_q, s_ovf_v_q;
    logic                 s_sing_d, s_ovf_u_d, s_ovf_v_d;

    // a=IxIx b=IyIy c=IxIy d=IxIt e=IyIt
    assign p_ab_d = PW'(bus_io.sum_IxIx) * PW'(bus_io.sum_IyIy);
    assign p_cc_d = PW'(bus_io.sum_IxIy) * PW'(bus_io.sum_IxIy);
    assign p_ce_d = PW'(bus_io.sum_IxIy) * PW'(bus_io.sum_IyIt);
    assign p_bd_d = PW'(bus_io.sum_IyIy) * PW'(bus_io.sum_IxIt);
    assign p_cd_d = PW'(bus_io.sum_IxIy) * PW'(bus_io.sum_IxIt);
    assign p_ae_d = PW'(bus_io.sum_IxIx) * PW'(bus_io.sum_IyIt);
    assign det_d  = DW'(p_ab_q) - DW'(p_cc_q);
    assign nu_d   = DW'(p_ce_q) - DW'(p_bd_q);
    assign nv_d   = DW'(p_cd_q) - DW'(p_ae_q);

    always_comb begin
        logic [DW-1:0] nu_mag, nv_mag;
        logic [CW-1:0] det_lim;
        nu_mag    = nu_q[DW-1] ? -nu_q : nu_q;
        nv_mag    = nv_q[DW-1] ? -nv_q : nv_q;
        s_num_u_d = NW'(nu_mag) << FRAC_BITS;
        s_num_v_d = NW'(nv_mag) << FRAC_BITS;
        // Quotient would not fit in FLOW_WIDTH-1 magnitude bits.
        det_lim   = CW'($unsigned(det_q)) << (FLOW_WIDTH - 1);
        s_ovf_u_d = CW'(s_num_u_d) >= det_lim;
        s_ovf_v_d = CW'(s_num_v_d) >= det_lim;
        s_sing_d  = det_q <= DW'(DET_THRESH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {p_valid_q, d_valid_q, s_valid_q} <= '0;
            {p_x_q, d_x_q, s_x_q} <= '0;
            {p_y_q, d_y_q, s_y_q} <= '0;
            {p_ab_q, p_cc_q, p_ce_q, p_bd_q, p_cd_q, p_ae_q} <= '0;
            {det_q, nu_q, nv_q} <= '0;
            {s_num_u_q, s_num_v_q, s_det_q} <= '0;
            {s_sing_q, s_neg_u_q, s_neg_v_q, s_ovf_u_q, s_ovf_v_q} <= '0;
        end else begin
            p_valid_q <= bus_io.accum_valid;
            p_x_q     <= bus_io.accum_x_coord;
            p_y_q     <= bus_io.accum_y_coord;
            {p_ab_q, p_cc_q, p_ce_q} <= {p_ab_d, p_cc_d, p_ce_d};
            {p_bd_q, p_cd_q, p_ae_q} <= {p_bd_d, p_cd_d, p_ae_d};
            {d_valid_q, d_x_q, d_y_q} <= {p_valid_q, p_x_q, p_y_q};
            {det_q, nu_q, nv_q} <= {det_d, nu_d, nv_d};
            {s_valid_q, s_x_q, s_y_q} <= {d_valid_q, d_x_q, d_y_q};
            {s_num_u_q, s_num_v_q, s_det_q} <= {s_num_u_d, s_num_v_d, $unsigned(det_q)};
            {s_sing_q, s_ovf_u_q, s_ovf_v_q} <= {s_sing_d, s_ovf_u_d, s_ovf_v_d};
            s_neg_u_q <= nu_q[DW-1];
            s_neg_v_q <= nv_q[DW-1];
        end
    end

    logic                  vld_u, vld_v, div_valid, sing, neg_u, neg_v, ovf_u, ovf_v;
    logic [FLOW_WIDTH-1:0] quo_u, quo_v;
    logic [SIDE_U_W-1:0]   side_u;
    logic [1:0]            side_v;
    logic [X_W-1:0]        div_x;
    logic [Y_W-1:0]        div_y;

    flow_solver_divider #(
        .DIVIDEND_W(NW), .DIVISOR_W(DW), .Q_W(FLOW_WIDTH), .SIDE_W(SIDE_U_W)
    ) u_div_u (
        .clk(clk), .rst(rst), .valid_i(s_valid_q), .dividend_i(s_num_u_q), .divisor_i(s_det_q),
        .side_i({s_neg_u_q, s_ovf_u_q, s_sing_q, s_x_q, s_y_q}),
        .valid_o(vld_u), .quotient_o(quo_u), .side_o(side_u)
    );

    flow_solver_divider #(
        .DIVIDEND_W(NW), .DIVISOR_W(DW), .Q_W(FLOW_WIDTH), .SIDE_W(2)
    ) u_div_v (
        .clk(clk), .rst(rst), .valid_i(s_valid_q), .dividend_i(s_num_v_q), .divisor_i(s_det_q),
        .side_i({s_neg_v_q, s_ovf_v_q}),
        .valid_o(vld_v), .quotient_o(quo_v), .side_o(side_v)
    );

    assign div_valid = vld_u & vld_v;
    assign {neg_u, ovf_u, sing, div_x, div_y} = side_u;
    assign {neg_v, ovf_v} = side_v;

    function automatic logic signed [FLOW_WIDTH-1:0] pick(input logic singular, input logic ovf,
                                                          input logic neg,
                                                          input logic [FLOW_WIDTH-1:0] q);
        if (singular) return '0;
        if (ovf) return neg ? SAT_NEG : SAT_POS;
        return neg ? -q : q;
    endfunction

    logic signed [FLOW_WIDTH-1:0] out_u_q, out_u_d, out_v_q, out_v_d;
    logic                         out_sing_q, out_sing_d, out_sat_q, out_sat_d, out_valid_q;
    logic [X_W-1:0]               out_x_q, out_x_d;
    logic [Y_W-1:0]               out_y_q, out_y_d;

    // Data outputs hold their last value on idle cycles.
    always_comb begin
        out_u_d    = out_u_q;
        out_v_d    = out_v_q;
        out_sing_d = out_sing_q;
        out_sat_d  = out_sat_q;
        out_x_d    = out_x_q;
        out_y_d    = out_y_q;
        if (div_valid) begin
            out_u_d    = pick(sing, ovf_u, neg_u, quo_u);
            out_v_d    = pick(sing, ovf_v, neg_v, quo_v);
            out_sing_d = sing;
            out_sat_d  = !sing && (ovf_u || ovf_v);
            out_x_d    = div_x;
            out_y_d    = div_y;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {out_u_q, out_v_q, out_sing_q, out_sat_q, out_valid_q} <= '0;
            {out_x_q, out_y_q} <= '0;
        end else begin
            {out_u_q, out_v_q, out_sing_q, out_sat_q} <= {out_u_d, out_v_d, out_sing_d, out_sat_d};
            {out_x_q, out_y_q} <= {out_x_d, out_y_d};
            out_valid_q <= div_valid;
        end
    end

    assign bus_io.flow_u        = out_u_q;
    assign bus_io.flow_v        = out_v_q;
    assign bus_io.flow_singular = out_sing_q;
    assign bus_io.flow_sat      = out_sat_q;
    assign bus_io.flow_x_coord  = out_x_q;
    assign bus_io.flow_y_coord  = out_y_q;
    assign bus_io.flow_valid    = out_valid_q;

`ifdef FLOW_SOLVER_STATS_EN
    logic [15:0] cnt_q, cnt_d;

    // Pixel (0,0) starts a new frame: count restarts from that pixel alone.
    always_comb begin
        cnt_d = cnt_q;
        if (div_valid) begin
            if (div_x == '0 && div_y == '0) cnt_d = {15'd0, sing};
            else if (sing && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign bus_io.singular_count = cnt_q;
`endif

endmodule

// File: tb/tb_flow_solver.sv
// Self-checking bench for flow_solver: directed vector table, random stream and mid-stream reset.
// Checks singular_count as well when FLOW_SOLVER_STATS_EN is defined.
module tb_flow_solver;
    import flow_solver_pkg::*;

    localparam int LAT = int'(latency(FLOW_WIDTH_DEF));

    typedef struct {
        flow_t          exp;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        int             cyc;
    } sb_t;

    typedef struct {
        tensor_t t;
        flow_t   e;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   n_out = 0;
    sb_t  sb_q[$];
`ifdef FLOW_SOLVER_STATS_EN
    int   exp_cnt = 0;
`endif

    flow_solver_if #(.ACCUM_WIDTH(ACCUM_WIDTH_DEF), .FLOW_WIDTH(FLOW_WIDTH_DEF)) bus ();

    flow_solver #(
        .ACCUM_WIDTH(ACCUM_WIDTH_DEF), .FLOW_WIDTH(FLOW_WIDTH_DEF),
        .FRAC_BITS(FRAC_BITS_DEF), .DET_THRESH(DET_THRESH_DEF)
    ) dut (
        .clk(clk), .rst(rst), .bus_io(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic tensor_t mk(input int a, input int b, input int c, input int d, input int e);
        tensor_t t;
        t.ixix = a; t.iyiy = b; t.ixiy = c; t.ixit = d; t.iyit = e;
        return t;
    endfunction

    function automatic flow_t mkf(input int u, input int v, input logic s, input logic sat);
        flow_t f;
        f.u = 16'(u); f.v = 16'(v); f.singular = s; f.sat = sat;
        return f;
    endfunction

    // Reference: wide exact arithmetic and the built-in divide.
    function automatic logic signed [15:0] ref_div(input logic signed [67:0] n,
                                                   input logic signed [67:0] det,
                                                   output logic sat);
        logic [135:0] mag, q;
        mag = (n < 0) ? 136'(-n) : 136'(n);
        q   = (mag << 8) / 136'(det);
        sat = (q > 136'd32767);
        if (sat) return (n < 0) ? -16'sd32767 : 16'sd32767;
        return (n < 0) ? -16'(q) : 16'(q);
    endfunction

    function automatic flow_t ref_flow(input tensor_t t);
        logic signed [67:0] a, b, c, d, e, det, nu, nv;
        logic su, sv;
        flow_t r;
        a = 68'(t.ixix); b = 68'(t.iyiy); c = 68'(t.ixiy); d = 68'(t.ixit); e = 68'(t.iyit);
        det = a * b - c * c;
        nu  = c * e - b * d;
        nv  = c * d - a * e;
        r = '0;
        r.singular = (det <= 68'sd16);
        if (!r.singular) begin
            r.u = ref_div(nu, det, su);
            r.v = ref_div(nv, det, sv);
            r.sat = su | sv;
        end
        return r;
    endfunction

    function automatic tensor_t rnd_tensor(input int i);
        if (i % 4 == 0)
            return mk(int'($urandom), int'($urandom), int'($urandom), int'($urandom),
                      int'($urandom));
        return mk(int'($urandom_range(0, 4000)), int'($urandom_range(0, 4000)),
                  int'($urandom_range(0, 2000)) - 1000, int'($urandom_range(0, 100000)) - 50000,
                  int'($urandom_range(0, 100000)) - 50000);
    endfunction

    task automatic drive(input tensor_t t, input logic [X_W-1:0] x, input logic [Y_W-1:0] y,
                         input flow_t e);
        sb_t s;
        bus.sum_IxIx = t.ixix; bus.sum_IyIy = t.iyiy; bus.sum_IxIy = t.ixiy;
        bus.sum_IxIt = t.ixit; bus.sum_IyIt = t.iyit;
        bus.accum_x_coord = x; bus.accum_y_coord = y; bus.accum_valid = 1'b1;
        s.exp = e; s.x = x; s.y = y; s.cyc = cyc;
        sb_q.push_back(s);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        bus.accum_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        bus.accum_valid = 1'b0;
        while (sb_q.size() != 0 && n < budget) begin @(posedge clk); #1; n++; end
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: outstanding=%0d, want 0 within %0d cycles", sb_q.size(), budget);
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        sb_t   e;
        flow_t got;
        if (rst !== 1'b1 && bus.flow_valid === 1'b1) begin
            n_out++;
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_out: got valid at x=%0d y=%0d, want no output",
                         bus.flow_x_coord, bus.flow_y_coord);
            end else begin
                e = sb_q.pop_front();
                got.u = bus.flow_u; got.v = bus.flow_v;
                got.singular = bus.flow_singular; got.sat = bus.flow_sat;
                if (got !== e.exp || bus.flow_x_coord !== e.x || bus.flow_y_coord !== e.y ||
                    cyc - e.cyc != LAT) begin
                    bad++;
                    $display("FAIL out(%0d,%0d): got u=%0d v=%0d sing=%0b sat=%0b x=%0d y=%0d lat=%0d; want u=%0d v=%0d sing=%0b sat=%0b x=%0d y=%0d lat=%0d",
                             e.x, e.y, got.u, got.v, got.singular, got.sat, bus.flow_x_coord,
                             bus.flow_y_coord, cyc - e.cyc, e.exp.u, e.exp.v, e.exp.singular,
                             e.exp.sat, e.x, e.y, LAT);
                end
`ifdef FLOW_SOLVER_STATS_EN
                if (e.x == '0 && e.y == '0) exp_cnt = e.exp.singular ? 1 : 0;
                else if (e.exp.singular && exp_cnt != 16'hFFFF) exp_cnt++;
                total++;
                if (bus.singular_count !== 16'(exp_cnt)) begin
                    bad++;
                    $display("FAIL singular_count: got %0d, want %0d", bus.singular_count, exp_cnt);
                end
`endif
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  vecs[13];
        tensor_t t;
        int    n_before;

        vecs[0]  = '{t: mk(256, 256, 0, -256, 0),         e: mkf(256, 0, 0, 0)};
        vecs[1]  = '{t: mk(256, 256, 0, 0, 512),          e: mkf(0, -512, 0, 0)};
        vecs[2]  = '{t: mk(0, 0, 0, 0, 0),                e: mkf(0, 0, 1, 0)};
        vecs[3]  = '{t: mk(4, 4, 4, 100, 200),            e: mkf(0, 0, 1, 0)};
        vecs[4]  = '{t: mk(64, 64, 0, -(1 << 20), 0),     e: mkf(32767, 0, 0, 1)};
        vecs[5]  = '{t: mk(64, 64, 0, 1 << 20, 0),        e: mkf(-32767, 0, 0, 1)};
        vecs[6]  = '{t: mk(4, 4, 0, -100, 0),             e: mkf(0, 0, 1, 0)};
        vecs[7]  = '{t: mk(17, 1, 0, -1, 0),              e: mkf(15, 0, 0, 0)};
        vecs[8]  = '{t: mk(17, 1, 0, 1, 0),               e: mkf(-15, 0, 0, 0)};
        vecs[9]  = '{t: mk(256, 1, 0, -32767, 0),         e: mkf(32767, 0, 0, 0)};
        vecs[10] = '{t: mk(256, 1, 0, -32768, 0),         e: mkf(32767, 0, 0, 1)};
        vecs[11] = '{t: mk(1, 1, 10, 5, 5),               e: mkf(0, 0, 1, 0)};
        vecs[12] = '{t: mk(256, 256, 128, 0, 3),          e: mkf(2, -4, 0, 0)};

        rst = 1'b1;
        bus.accum_valid = 1'b0;
        bus.sum_IxIx = '0; bus.sum_IyIy = '0; bus.sum_IxIy = '0;
        bus.sum_IxIt = '0; bus.sum_IyIt = '0;
        bus.accum_x_coord = '0; bus.accum_y_coord = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (bus.flow_valid !== 1'b0 || bus.flow_u !== '0 || bus.flow_v !== '0 ||
            bus.flow_singular !== 1'b0 || bus.flow_sat !== 1'b0 ||
            bus.flow_x_coord !== '0 || bus.flow_y_coord !== '0) begin
            bad++;
            $display("FAIL reset_state: got valid=%b u=%0d v=%0d sing=%b sat=%b; want all 0",
                     bus.flow_valid, bus.flow_u, bus.flow_v, bus.flow_singular, bus.flow_sat);
        end
`ifdef FLOW_SOLVER_STATS_EN
        total++;
        if (bus.singular_count !== 16'd0) begin
            bad++;
            $display("FAIL reset_count: got %0d, want 0", bus.singular_count);
        end
`endif
        rst = 1'b0;
        idle(2);

        for (int i = 0; i < 13; i++) drive(vecs[i].t, 10'(100 + i), 9'(i + 1), vecs[i].e);
        drain(100);

        for (int i = 0; i < 100; i++) begin
            t = rnd_tensor(i);
            drive(t, 10'(i + 1), 9'((i * 3) % 500 + 1), ref_flow(t));
        end
        drain(100);

        // Mid-stream reset with outputs already flowing and more samples in flight.
        for (int i = 0; i < 25; i++) begin
            t = rnd_tensor(i + 7);
            drive(t, 10'(500 + i), 9'(7), ref_flow(t));
        end
        bus.accum_valid = 1'b0;
        rst = 1'b1;
        sb_q.delete();
`ifdef FLOW_SOLVER_STATS_EN
        exp_cnt = 0;
`endif
        #1;
        total++;
        if (bus.flow_valid !== 1'b0 || bus.flow_u !== '0 || bus.flow_v !== '0) begin
            bad++;
            $display("FAIL async_reset: got valid=%b u=%0d v=%0d; want 0 0 0",
                     bus.flow_valid, bus.flow_u, bus.flow_v);
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        n_before = n_out;
        idle(30);
        total++;
        if (n_out != n_before) begin
            bad++;
            $display("FAIL stale_after_reset: got %0d outputs, want 0", n_out - n_before);
        end

        // Frame restart at (0,0) followed by a mix of singular and solvable pixels.
        drive(vecs[2].t, 10'd0, 9'd0, vecs[2].e);
        drive(vecs[3].t, 10'd1, 9'd0, vecs[3].e);
        drive(vecs[0].t, 10'd2, 9'd0, vecs[0].e);
        idle(3);
        drive(vecs[6].t, 10'd3, 9'd0, vecs[6].e);
        drive(vecs[12].t, 10'd4, 9'd0, vecs[12].e);
        drain(100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
